// File: rtl/hub75_pkg.sv
// hub75_pkg: shared constants, pixel/row types and output FSM states for the HUB75 row capture block.
package hub75_pkg;
    localparam int COLS = 64;
    localparam int BPP = 3;
    localparam int ROW_AW = 5;
    localparam int HALF_ROWS = 2 ** (ROW_AW - 1);
    localparam int ROW_W = COLS * BPP;
    localparam int CNT_W = $clog2(COLS + 2);
    typedef logic [BPP-1:0] pixel_t;
    typedef logic [ROW_W-1:0] row_t;
    typedef enum logic [1:0] {EMPTY, UPPER, LOWER} out_state_t;
    typedef struct packed {
        logic                         sclk;
        logic                         lat;
        logic                         oe;
        logic [$clog2(HALF_ROWS)-1:0] addr;
        pixel_t                       p0;
        pixel_t                       p1;
    } hub_t;
endpackage

// File: rtl/hub75_in_sync.sv
// hub75_in_sync: optional 2-flop synchronizer (HUB75_CAPTURE_SYNC_EN), sample register and sclk/lat rise detect.
// The sclk/lat fields of o_hub carry one-cycle rise pulses aligned with the sampled data.
module hub75_in_sync
    import hub75_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  hub_t i_hub,
    output hub_t o_hub
);
    hub_t w_in;
`ifdef HUB75_CAPTURE_SYNC_EN
    hub_t r_meta;
    hub_t r_sync;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_hub;
            r_sync <= r_meta;
        end
    end
    assign w_in = r_sync;
`else
    assign w_in = i_hub;
`endif
    hub_t       r_smp;
    logic       r_seen;
    logic [1:0] r_prev;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_smp  <= '0;
            r_seen <= 1'b0;
            r_prev <= '0;
            o_hub  <= '0;
        end else begin
            r_smp  <= w_in;
            r_seen <= 1'b1;
            // first sample after reset seeds the history so it cannot look like an edge
            r_prev <= r_seen ? {r_smp.sclk, r_smp.lat} : {w_in.sclk, w_in.lat};
            o_hub      <= r_smp;
            o_hub.sclk <= r_smp.sclk & ~r_prev[1];
            o_hub.lat  <= r_smp.lat & ~r_prev[0];
        end
    end
endmodule

// File: rtl/hub75_row_capture.sv
// hub75_row_capture: rebuilds latched HUB75 double-rows into upper/lower pixel rows on a valid/ready stream.
// Define HUB75_CAPTURE_SYNC_EN to add a 2-flop input synchronizer for an asynchronous panel source.
module hub75_row_capture
    import hub75_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hub_sclk,
    input  logic              i_hub_lat,
    input  logic              i_hub_oe,
    input  logic              i_hub_a,
    input  logic              i_hub_b,
    input  logic              i_hub_c,
    input  logic              i_hub_d,
    input  logic              i_hub_r0,
    input  logic              i_hub_g0,
    input  logic              i_hub_b0,
    input  logic              i_hub_r1,
    input  logic              i_hub_g1,
    input  logic              i_hub_b1,
    output logic              o_row_valid,
    input  logic              i_row_ready,
    output logic [ROW_AW-1:0] o_row_addr,
    output logic [ROW_W-1:0]  o_row_data,
    output logic              o_col_err,
    output logic              o_ovf_err,
    output logic              o_oe_err
);
    hub_t w_raw;
    hub_t w_hub;
    assign w_raw = {i_hub_sclk, i_hub_lat, i_hub_oe, i_hub_d, i_hub_c, i_hub_b, i_hub_a,
                    i_hub_r0, i_hub_g0, i_hub_b0, i_hub_r1, i_hub_g1, i_hub_b1};
    hub75_in_sync u_in_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_hub (w_raw),
        .o_hub (w_hub)
    );
    row_t              r_sh0, r_sh1, r_buf0, r_buf1, w_sh0, w_sh1;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic [ROW_AW-2:0] r_addr;
    logic              r_col_err, r_ovf_err, r_oe_err;
    out_state_t        r_state, w_state;
    logic              w_hs, w_free, w_commit;
    // a pixel shifted in the latch cycle is part of the committed row
    assign w_sh0    = w_hub.sclk ? {r_sh0[ROW_W-BPP-1:0], w_hub.p0} : r_sh0;
    assign w_sh1    = w_hub.sclk ? {r_sh1[ROW_W-BPP-1:0], w_hub.p1} : r_sh1;
    assign w_cnt    = (w_hub.sclk && r_cnt != CNT_W'(COLS + 1)) ? r_cnt + 1'b1 : r_cnt;
    assign w_hs     = o_row_valid && i_row_ready;
    assign w_free   = r_state == EMPTY || (r_state == LOWER && w_hs);
    assign w_commit = w_hub.lat && w_free;
    always_comb begin
        w_state = r_state;
        if (w_commit)
            w_state = UPPER;
        else if (w_hs)
            w_state = (r_state == UPPER) ? LOWER : EMPTY;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_state <= EMPTY;
        else
            r_state <= w_state;
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh0     <= '0;
            r_sh1     <= '0;
            r_buf0    <= '0;
            r_buf1    <= '0;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_col_err <= 1'b0;
            r_ovf_err <= 1'b0;
            r_oe_err  <= 1'b0;
        end else begin
            r_sh0 <= w_sh0;
            r_sh1 <= w_sh1;
            r_cnt <= w_hub.lat ? '0 : w_cnt;
            if (w_commit) begin
                r_buf0 <= w_sh0;
                r_buf1 <= w_sh1;
                r_addr <= w_hub.addr;
            end
            r_col_err <= w_commit && w_cnt != CNT_W'(COLS);
            r_ovf_err <= w_hub.lat && !w_free;
            r_oe_err  <= w_hub.sclk && !w_hub.oe;
        end
    end
    assign o_row_valid = r_state != EMPTY;
    assign o_row_addr  = o_row_valid ? {r_state == LOWER, r_addr} : '0;
    assign o_row_data  = (r_state == UPPER) ? r_buf0 : ((r_state == LOWER) ? r_buf1 : '0);
    assign o_col_err   = r_col_err;
    assign o_ovf_err   = r_ovf_err;
    assign o_oe_err    = r_oe_err;
endmodule

// File: tb/tb_hub75_row_capture.sv
// tb_hub75_row_capture: directed/random HUB75 stimulus against a pixel-history model of the panel rows.
module tb_hub75_row_capture;
    import hub75_pkg::*;
`ifdef HUB75_CAPTURE_SYNC_EN
    localparam int LAT_K = 3;
`else
    localparam int LAT_K = 1;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic sclk = 1'b0, lat = 1'b0, oe = 1'b1, ready = 1'b1;
    logic [3:0] addr = '0;
    pixel_t p0 = '0, p1 = '0;
    logic row_valid, col_err, ovf_err, oe_err;
    logic [ROW_AW-1:0] row_addr;
    logic [ROW_W-1:0] row_data;
    hub75_row_capture dut (
        .i_clk(clk), .i_rst(rst),
        .i_hub_sclk(sclk), .i_hub_lat(lat), .i_hub_oe(oe),
        .i_hub_a(addr[0]), .i_hub_b(addr[1]), .i_hub_c(addr[2]), .i_hub_d(addr[3]),
        .i_hub_r0(p0[2]), .i_hub_g0(p0[1]), .i_hub_b0(p0[0]),
        .i_hub_r1(p1[2]), .i_hub_g1(p1[1]), .i_hub_b1(p1[0]),
        .o_row_valid(row_valid), .i_row_ready(ready), .o_row_addr(row_addr), .o_row_data(row_data),
        .o_col_err(col_err), .o_ovf_err(ovf_err), .o_oe_err(oe_err)
    );
    int checks = 0, errors = 0;
    int n_col = 0, n_ovf = 0, n_oe = 0;
    always @(posedge clk) begin
        #2;
        if (col_err) n_col++;
        if (ovf_err) n_ovf++;
        if (oe_err) n_oe++;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    // panel model: each half keeps the last COLS pixels ever shifted, oldest at col 0
    pixel_t q0[$], q1[$];
    row_t e0, e1;
    pixel_t img[2*HALF_ROWS][COLS];
    function automatic row_t pack(input pixel_t q[$]);
        row_t r = '0;
        for (int c = 0; c < COLS; c++) r[ROW_W-1-BPP*c -: BPP] = q[c];
        return r;
    endfunction
    function automatic row_t pack_img(input int r);
        pixel_t q[$];
        for (int c = 0; c < COLS; c++) q.push_back(img[r][c]);
        return pack(q);
    endfunction
    task automatic tick;
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset;
        q0.delete();
        q1.delete();
        for (int c = 0; c < COLS; c++) begin
            q0.push_back('0);
            q1.push_back('0);
        end
    endtask
    task automatic shift_px(input pixel_t a, input pixel_t b, input logic o);
        sclk = 1'b0; p0 = a; p1 = b; oe = o;
        tick;
        sclk = 1'b1;
        tick;
        q0.push_back(a); void'(q0.pop_front());
        q1.push_back(b); void'(q1.pop_front());
    endtask
    task automatic shift_rand(input int n);
        for (int i = 0; i < n; i++) shift_px(pixel_t'($urandom), pixel_t'($urandom), 1'b1);
    endtask
    task automatic latch(input logic [3:0] a);
        sclk = 1'b0; oe = 1'b1; addr = a; lat = 1'b1;
        e0 = pack(q0); e1 = pack(q1);
        tick;
        lat = 1'b0;
        tick;
    endtask
    task automatic wait_valid(output int k);
        k = 0;
        while (!row_valid && k < 20) begin
            tick;
            k++;
        end
        chk("valid_rise", row_valid, 1);
    endtask
    task automatic expect_row(input logic [3:0] a, input row_t x0, input row_t x1, input logic cerr, input bit chk_lat);
        int k;
        wait_valid(k);
        if (chk_lat) chk("latency", k, LAT_K);
        chk("col_err", col_err, cerr);
        chk("addr_upper", row_addr, {1'b0, a});
        chk("data_upper", row_data, x0);
        tick;
        chk("addr_lower", row_addr, {1'b1, a});
        chk("data_lower", row_data, x1);
        tick;
        chk("valid_fall", row_valid, 0);
    endtask
    initial begin
        int k, n;
        row_t x0, x1;
        model_reset();
        repeat (3) tick;
        chk("rst_valid", row_valid, 0);
        chk("rst_addr", row_addr, 0);
        chk("rst_data", row_data, 0);
        chk("rst_col_err", col_err, 0);
        chk("rst_ovf_err", ovf_err, 0);
        chk("rst_oe_err", oe_err, 0);
        rst = 1'b0;
        tick;
        for (int c = 0; c < COLS; c++) shift_px(pixel_t'(c), ~pixel_t'(c), 1'b1);
        latch(4'd5);
        expect_row(4'd5, e0, e1, 1'b0, 1'b1);
        shift_rand(COLS);
        ready = 1'b0;
        latch(4'd7);
        x0 = e0; x1 = e1;
        wait_valid(k);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("hold_valid", row_valid, 1);
            chk("hold_data", row_data, x0);
        end
        shift_rand(COLS);
        n = n_ovf;
        latch(4'd9);
        tick;
        chk("ovf_pulse", n_ovf - n, 1);
        chk("ovf_intact", row_data, x0);
        ready = 1'b1;
        expect_row(4'd7, x0, x1, 1'b0, 1'b0);
        shift_rand(COLS - 1);
        latch(4'd3);
        expect_row(4'd3, e0, e1, 1'b1, 1'b1);
        shift_rand(COLS + 2);
        latch(4'd4);
        expect_row(4'd4, e0, e1, 1'b1, 1'b1);
        for (int c = 0; c < COLS - 1; c++) shift_px(pixel_t'($urandom), pixel_t'($urandom), c != 10);
        sclk = 1'b0; p0 = pixel_t'($urandom); p1 = pixel_t'($urandom);
        tick;
        sclk = 1'b1; lat = 1'b1; addr = 4'd11;
        q0.push_back(p0); void'(q0.pop_front());
        q1.push_back(p1); void'(q1.pop_front());
        e0 = pack(q0); e1 = pack(q1);
        tick;
        sclk = 1'b0; lat = 1'b0;
        tick;
        expect_row(4'd11, e0, e1, 1'b0, 1'b0);
        chk("oe_err_count", n_oe, 1);
        shift_rand(COLS);
        ready = 1'b0;
        latch(4'd2);
        wait_valid(k);
        rst = 1'b1;
        tick;
        chk("midrst_valid", row_valid, 0);
        chk("midrst_data", row_data, 0);
        chk("midrst_addr", row_addr, 0);
        rst = 1'b0;
        model_reset();
        tick;
        shift_rand(COLS);
        ready = 1'b1;
        latch(4'd6);
        expect_row(4'd6, e0, e1, 1'b0, 1'b1);
        for (int r = 0; r < 2 * HALF_ROWS; r++)
            for (int c = 0; c < COLS; c++) img[r][c] = pixel_t'($urandom);
        for (int a = 0; a < HALF_ROWS; a++) begin
            for (int c = 0; c < COLS; c++) shift_px(img[a][c], img[a+HALF_ROWS][c], 1'b1);
            latch(4'(a));
            expect_row(4'(a), pack_img(a), pack_img(a + HALF_ROWS), 1'b0, 1'b0);
        end
        tick;
        chk("col_err_total", n_col, 2);
        chk("ovf_err_total", n_ovf, 1);
        chk("oe_err_total", n_oe, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
